// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer: one outstanding SRAM-like bus
// transaction, stall request until completion, aligned/extended load return.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stallreq,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  localparam int unsigned CNT_W = 10;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic        uns_q, uns_nxt;
  logic        data_req_nxt, data_wr_nxt;
  logic [1:0]  data_size_nxt;
  logic [31:0] data_addr_nxt, data_wdata_nxt;
  logic [3:0]  data_wstrb_nxt;
  logic        resp_valid_nxt, resp_err_nxt;
  logic [31:0] resp_rdata_nxt;

  logic        illegal_c;
  logic [3:0]  strb_c;
  logic [31:0] lanes_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;
  logic [31:0] load_c;

  // Stall while a request waits in IDLE or a bus transaction is in flight
  assign stallreq = ~rst & (((state == IDLE) & req_valid) | (state == ADDR) | (state == DATA));

  // Misaligned or unsupported access size
  assign illegal_c = (req_size == 2'd3) |
                     ((req_size == 2'd1) & req_addr[0]) |
                     ((req_size == 2'd2) & (req_addr[1:0] != 2'b00));

  // Store byte strobes and lane-replicated write data
  always_comb begin
    strb_c  = 4'b1111;
    lanes_c = req_wdata;
    case (req_size)
      2'd0: begin
        strb_c  = 4'b0001 << req_addr[1:0];
        lanes_c = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        strb_c  = req_addr[1] ? 4'b1100 : 4'b0011;
        lanes_c = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extraction and sign/zero extension from the latched request
  always_comb begin
    byte_c = data_rdata[7:0];
    half_c = data_addr[1] ? data_rdata[31:16] : data_rdata[15:0];
    load_c = data_rdata;
    case (data_addr[1:0])
      2'd1:    byte_c = data_rdata[15:8];
      2'd2:    byte_c = data_rdata[23:16];
      2'd3:    byte_c = data_rdata[31:24];
      default: ;
    endcase
    case (data_size)
      2'd0:    load_c = {{24{~uns_q & byte_c[7]}}, byte_c};
      2'd1:    load_c = {{16{~uns_q & half_c[15]}}, half_c};
      default: ;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    uns_nxt        = uns_q;
    data_req_nxt   = data_req;
    data_wr_nxt    = data_wr;
    data_size_nxt  = data_size;
    data_addr_nxt  = data_addr;
    data_wstrb_nxt = data_wstrb;
    data_wdata_nxt = data_wdata;
    resp_valid_nxt = 1'b0;
    resp_err_nxt   = 1'b0;
    resp_rdata_nxt = 32'd0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (illegal_c) begin
            state_nxt      = DONE;
            resp_valid_nxt = 1'b1;
            resp_err_nxt   = 1'b1;
          end else begin
            state_nxt      = ADDR;
            data_req_nxt   = 1'b1;
            data_wr_nxt    = req_wr;
            data_size_nxt  = req_size;
            data_addr_nxt  = req_addr;
            uns_nxt        = req_unsigned;
            data_wstrb_nxt = req_wr ? strb_c : 4'b0000;
            data_wdata_nxt = req_wr ? lanes_c : 32'd0;
          end
        end
      end
      ADDR: begin
        if (data_addr_ok) begin
          state_nxt    = DATA;
          data_req_nxt = 1'b0;
          cnt_nxt      = '0;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_nxt      = DONE;
          data_req_nxt   = 1'b0;
          cnt_nxt        = '0;
          resp_valid_nxt = 1'b1;
          resp_err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (data_data_ok) begin
          state_nxt      = DONE;
          resp_valid_nxt = 1'b1;
          resp_rdata_nxt = data_wr ? 32'd0 : load_c;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      uns_q      <= 1'b0;
      data_req   <= 1'b0;
      data_wr    <= 1'b0;
      data_size  <= 2'd0;
      data_addr  <= 32'd0;
      data_wstrb <= 4'd0;
      data_wdata <= 32'd0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      uns_q      <= uns_nxt;
      data_req   <= data_req_nxt;
      data_wr    <= data_wr_nxt;
      data_size  <= data_size_nxt;
      data_addr  <= data_addr_nxt;
      data_wstrb <= data_wstrb_nxt;
      data_wdata <= data_wdata_nxt;
      resp_valid <= resp_valid_nxt;
      resp_err   <= resp_err_nxt;
      resp_rdata <= resp_rdata_nxt;
    end
  end

endmodule
